// File: rtl/tt_sweep_pkg.sv
// Shared types and limits for the truth-table sweeper.
package tt_sweep_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int N_IN_MAX   = 4;
    localparam int SETTLE_MAX = 15;

    function automatic int depth_of(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_sweeper.sv
// Walks every input combination through a combinational function unit,
// captures its truth table and scores it against a golden pattern.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [depth_of(N_IN)-1:0] expected,
    output logic [N_IN-1:0]           func_in,
    input  logic                      func_out,
    output logic                      busy,
    output logic                      done,
    output logic [depth_of(N_IN)-1:0] table_out,
    output logic [N_IN:0]             mismatch_cnt,
    output logic                      pass
);

    localparam int              DEPTH     = depth_of(N_IN);
    localparam logic [3:0]      SETTLE_LD = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] IDX_LAST  = N_IN'(DEPTH - 1);

    if (N_IN < 1 || N_IN > N_IN_MAX) begin : g_bad_n_in
        $error("truth_table_sweeper: N_IN out of range");
    end
    if (SETTLE < 1 || SETTLE > SETTLE_MAX) begin : g_bad_settle
        $error("truth_table_sweeper: SETTLE out of range");
    end

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [3:0]        settle_q, settle_d;
    logic [DEPTH-1:0]  exp_q, exp_d;
    logic [N_IN-1:0]   func_in_d;
    logic              busy_d, done_d, pass_d;
    logic [DEPTH-1:0]  table_d;
    logic [N_IN:0]     cnt_d;
    logic [N_IN:0]     miss_inc;

    assign miss_inc = {{N_IN{1'b0}}, (func_out != exp_q[idx_q])};

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        settle_d  = settle_q;
        exp_d     = exp_q;
        func_in_d = func_in;
        busy_d    = busy;
        done_d    = 1'b0;
        table_d   = table_out;
        cnt_d     = mismatch_cnt;
        pass_d    = pass;
        case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d     = expected;
                    table_d   = '0;
                    cnt_d     = '0;
                    pass_d    = 1'b0;
                    idx_d     = '0;
                    func_in_d = '0;
                    settle_d  = SETTLE_LD;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (settle_q != 4'd0) begin
                    settle_d = settle_q - 4'd1;
                end else begin
                    table_d[idx_q] = func_out;
                    cnt_d          = mismatch_cnt + miss_inc;
                    if (idx_q != IDX_LAST) begin
                        idx_d     = idx_q + 1'b1;
                        func_in_d = idx_q + 1'b1;
                        settle_d  = SETTLE_LD;
                    end else begin
                        // Pass uses the count including this final sample.
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        pass_d    = (cnt_d == '0);
                        func_in_d = '0;
                        idx_d     = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            settle_q     <= '0;
            exp_q        <= '0;
            func_in      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            pass         <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            settle_q     <= settle_d;
            exp_q        <= exp_d;
            func_in      <= func_in_d;
            busy         <= busy_d;
            done         <= done_d;
            table_out    <= table_d;
            mismatch_cnt <= cnt_d;
            pass         <= pass_d;
        end
    end

endmodule
